// File: rtl/change_dispenser.sv
// Change dispenser: greedily pays out an amount from per-denomination coin stock,
// one coin per hopper handshake, largest eligible denomination first.
module change_dispenser #(
  parameter int          NUM_COINS  = 3,
  parameter int unsigned COIN_VAL0  = 100,
  parameter int unsigned COIN_VAL1  = 500,
  parameter int unsigned COIN_VAL2  = 1000,
  parameter int          STOCK_W    = 8,
  parameter int          INIT_STOCK = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_start,
  input  logic [31:0]          i_amount,
  output logic                 o_ready,
  output logic                 o_coin_valid,
  output logic [NUM_COINS-1:0] o_coin,
  input  logic                 i_coin_ack,
  output logic [31:0]          o_remaining,
  output logic                 o_done,
  output logic                 o_short,
  input  logic [NUM_COINS-1:0] i_refill,
  output logic [NUM_COINS-1:0] o_stock_empty
);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_e;

  state_e                              state_q;
  logic [NUM_COINS-1:0][STOCK_W-1:0]   stock_q, stock_d;
  logic [NUM_COINS-1:0]                coin_q;
  logic                                coin_valid_q, done_q, short_q;
  logic [31:0]                         remaining_q;

  logic [NUM_COINS-1:0]                elig, sel_oh;
  logic [NUM_COINS-1:0][31:0]          cval_m;
  logic [31:0]                         cur_val;
  logic                                sel_any, ack_fire;

  function automatic logic [31:0] coin_val(input int j);
    case (j)
      0:       coin_val = COIN_VAL0;
      1:       coin_val = COIN_VAL1;
      default: coin_val = COIN_VAL2;
    endcase
  endfunction

  assign ack_fire = (state_q == ISSUE) && coin_valid_q && i_coin_ack;
  assign sel_any  = |elig;

  for (genvar g = 0; g < NUM_COINS; g++) begin : g_coin
    logic dec;
    assign elig[g]   = (coin_val(g) <= remaining_q) && (stock_q[g] != '0);
    // Only the highest eligible denomination survives.
    if (g == NUM_COINS-1) begin : g_top
      assign sel_oh[g] = elig[g];
    end else begin : g_low
      assign sel_oh[g] = elig[g] & ~(|elig[NUM_COINS-1:g+1]);
    end
    assign cval_m[g] = coin_q[g] ? coin_val(g) : 32'd0;

    // A refill landing on the same edge as a dispensed coin cancels out.
    assign dec        = ack_fire & coin_q[g];
    assign stock_d[g] = (dec && !i_refill[g])                        ? stock_q[g] - STOCK_W'(1) :
                        (i_refill[g] && !dec && (stock_q[g] != '1))  ? stock_q[g] + STOCK_W'(1) :
                                                                       stock_q[g];
    assign o_stock_empty[g] = (stock_q[g] == '0);
  end

  always_comb begin
    cur_val = '0;
    for (int j = 0; j < NUM_COINS; j++) cur_val = cur_val | cval_m[j];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) stock_q <= {NUM_COINS{STOCK_W'(INIT_STOCK)}};
    else          stock_q <= stock_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      coin_q       <= '0;
      coin_valid_q <= 1'b0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
      remaining_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_start) begin
          remaining_q <= i_amount;
          state_q     <= SELECT;
        end
        SELECT: if (sel_any) begin
          coin_q       <= sel_oh;
          coin_valid_q <= 1'b1;
          state_q      <= ISSUE;
        end else begin
          done_q  <= 1'b1;
          short_q <= (remaining_q != '0);
          state_q <= DONE;
        end
        // Selection guarantees cur_val <= remaining_q, so no underflow.
        ISSUE: if (ack_fire) begin
          remaining_q  <= remaining_q - cur_val;
          coin_q       <= '0;
          coin_valid_q <= 1'b0;
          state_q      <= SELECT;
        end
        DONE: begin
          done_q  <= 1'b0;
          short_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready      = (state_q == IDLE);
  assign o_coin_valid = coin_valid_q;
  assign o_coin       = coin_q;
  assign o_remaining  = remaining_q;
  assign o_done       = done_q;
  assign o_short      = short_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: table of full returns plus hand-written
// sequences for ack stalls, refill collisions, saturation and mid-return reset.
module tb_change_dispenser;
  localparam int NC = 3;

  logic          clk = 1'b0, reset_n = 1'b0, i_start = 1'b0, i_coin_ack = 1'b0;
  logic [31:0]   i_amount = '0;
  logic [NC-1:0] i_refill = '0;
  logic          o_ready, o_coin_valid, o_done, o_short;
  logic [NC-1:0] o_coin, o_stock_empty;
  logic [31:0]   o_remaining;

  int total = 0, bad = 0;

  change_dispenser dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_amount(i_amount),
    .o_ready(o_ready), .o_coin_valid(o_coin_valid), .o_coin(o_coin),
    .i_coin_ack(i_coin_ack), .o_remaining(o_remaining), .o_done(o_done),
    .o_short(o_short), .i_refill(i_refill), .o_stock_empty(o_stock_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] amount;
    int          ncoins;
    logic [2:0]  first;
    logic        shrt;
    logic [31:0] rem;
    int          done_cyc;  // -1: not checked
    int          s0, s1, s2;
    logic        chk_empty2;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int coin_value(input logic [2:0] oh);
    case (oh)
      3'b001:  coin_value = 100;
      3'b010:  coin_value = 500;
      3'b100:  coin_value = 1000;
      default: coin_value = 0;
    endcase
  endfunction

  task automatic start(input logic [31:0] a);
    i_start = 1'b1; i_amount = a;
    @(negedge clk);
    i_start = 1'b0; i_amount = 32'hDEAD_BEEF;
  endtask

  task automatic check_stock(input string tag, input int s0, input int s1, input int s2);
    check({tag, "_stock0"}, 32'(dut.stock_q[0]), 32'(s0));
    check({tag, "_stock1"}, 32'(dut.stock_q[1]), 32'(s1));
    check({tag, "_stock2"}, 32'(dut.stock_q[2]), 32'(s2));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int coins = 0, sum = 0, dcyc = -1, e2bad = 0, zbad = 0;
    logic [2:0] first = '0;
    logic done = 1'b0, gshort = 1'b0;
    logic [31:0] grem = '0;
    string t = $sformatf("v%0d", idx);
    start(v.amount);
    for (int c = 0; c < 100; c++) begin
      if (o_coin_valid) begin
        if (coins == 0) first = o_coin;
        coins++;
        sum += coin_value(o_coin);
      end else if (o_coin != '0) zbad++;
      if (v.chk_empty2 && !o_stock_empty[2]) e2bad++;
      if (o_done) begin done = 1'b1; dcyc = c; gshort = o_short; grem = o_remaining; end
      @(negedge clk);
      if (done) break;
    end
    check({t, "_done_seen"}, 32'(done), 1);
    check({t, "_ncoins"}, 32'(coins), 32'(v.ncoins));
    check({t, "_first"}, 32'(first), 32'(v.first));
    check({t, "_paid"}, 32'(sum), v.amount - v.rem);
    check({t, "_short"}, 32'(gshort), 32'(v.shrt));
    check({t, "_rem"}, grem, v.rem);
    if (v.done_cyc >= 0) check({t, "_done_cyc"}, 32'(dcyc), 32'(v.done_cyc));
    check({t, "_coin_zero"}, 32'(zbad), 0);
    if (v.chk_empty2) check({t, "_empty2_held"}, 32'(e2bad), 0);
    check({t, "_ready_after"}, 32'(o_ready), 1);
    check({t, "_done_pulse"}, 32'(o_done), 0);
    check({t, "_rem_hold"}, o_remaining, v.rem);
    check_stock(t, v.s0, v.s1, v.s2);
    check({t, "_empty"}, 32'(o_stock_empty), 32'({v.s2 == 0, v.s1 == 0, v.s0 == 0}));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1600, 3,  3'b100, 1'b0, 0,   7,  9, 9, 9, 1'b0};
    tbl[1] = '{150,  1,  3'b001, 1'b1, 50,  3,  8, 9, 9, 1'b0};
    tbl[2] = '{0,    0,  3'b000, 1'b0, 0,   1,  8, 9, 9, 1'b0};
    tbl[3] = '{9000, 9,  3'b100, 1'b0, 0,   -1, 8, 9, 0, 1'b0};
    tbl[4] = '{2000, 4,  3'b010, 1'b0, 0,   -1, 8, 5, 0, 1'b1};
    tbl[5] = '{3700, 13, 3'b010, 1'b1, 400, -1, 0, 0, 0, 1'b1};
    tbl[6] = '{50,   0,  3'b000, 1'b1, 50,  1,  0, 0, 0, 1'b1};

    do_reset();
    check("rst_ready", 32'(o_ready), 1);
    check("rst_valid", 32'(o_coin_valid), 0);
    check("rst_coin", 32'(o_coin), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_short", 32'(o_short), 0);
    check("rst_rem", o_remaining, 0);
    check("rst_empty", 32'(o_stock_empty), 0);
    check_stock("rst", 10, 10, 10);

    i_coin_ack = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

    // Saturating refill of denomination 0 from empty.
    i_refill = 3'b001;
    for (int k = 0; k < 260; k++) @(negedge clk);
    i_refill = '0;
    @(negedge clk);
    check("sat_stock0", 32'(dut.stock_q[0]), 255);
    check("sat_empty", 32'(o_stock_empty), 32'(3'b110));

    // Ack withheld on first coin of a 500 return.
    do_reset();
    i_coin_ack = 1'b0;
    start(500);
    check("lat_select_valid", 32'(o_coin_valid), 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d_valid", k), 32'(o_coin_valid), 1);
      check($sformatf("stall%0d_coin", k), 32'(o_coin), 32'(3'b010));
      check($sformatf("stall%0d_stock1", k), 32'(dut.stock_q[1]), 10);
      check($sformatf("stall%0d_rem", k), o_remaining, 500);
      @(negedge clk);
    end
    check("stall_still_valid", 32'(o_coin_valid), 1);
    i_coin_ack = 1'b1;
    @(negedge clk);
    i_coin_ack = 1'b0;
    check("stall_ack_valid", 32'(o_coin_valid), 0);
    check("stall_ack_coin", 32'(o_coin), 0);
    check("stall_ack_rem", o_remaining, 0);
    check("stall_ack_stock1", 32'(dut.stock_q[1]), 9);
    @(negedge clk);
    check("stall_done", 32'(o_done), 1);
    check("stall_short", 32'(o_short), 0);
    @(negedge clk);
    check("stall_idle_done", 32'(o_done), 0);
    check("stall_single_dec", 32'(dut.stock_q[1]), 9);

    // Refill of denomination 1 on the same edge as its coin ack.
    i_coin_ack = 1'b1;
    start(500);
    @(negedge clk);
    check("coll_valid", 32'(o_coin_valid), 1);
    i_refill = 3'b010;
    @(negedge clk);
    i_refill = '0;
    check("coll_stock1", 32'(dut.stock_q[1]), 9);
    check("coll_rem", o_remaining, 0);
    @(negedge clk);
    check("coll_done", 32'(o_done), 1);
    @(negedge clk);
    i_refill = 3'b010;
    @(negedge clk);
    i_refill = '0;
    check("refill_stock1", 32'(dut.stock_q[1]), 10);

    // Reset while a coin is being offered.
    i_coin_ack = 1'b0;
    start(1000);
    @(negedge clk);
    check("rsti_valid_before", 32'(o_coin_valid), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rsti_ready", 32'(o_ready), 1);
    check("rsti_valid", 32'(o_coin_valid), 0);
    check("rsti_coin", 32'(o_coin), 0);
    check("rsti_rem", o_remaining, 0);
    check_stock("rsti", 10, 10, 10);
    reset_n = 1'b1;
    @(negedge clk);
    check("rsti_ready_after", 32'(o_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_COINS, 3, number of coin denominations.
- COIN_VAL0, 100, value of denomination 0.
- COIN_VAL1, 500, value of denomination 1.
- COIN_VAL2, 1000, value of denomination 2 (largest).
- STOCK_W, 8, width of each per-denomination stock counter.
- INIT_STOCK, 10, stock per denomination after reset.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- reset_n, in, 1, synchronous active-low reset.
- i_start, in, 1, request to return i_amount.
- i_amount, in, 32, amount to return; sampled only on the accepting edge.
- o_ready, out, 1, block idle and able to accept i_start.
- o_coin_valid, out, 1, a coin is being offered to the hopper.
- o_coin, out, NUM_COINS, one-hot denomination of the offered coin; zero when o_coin_valid=0.
- i_coin_ack, in, 1, hopper accepted the offered coin.
- o_remaining, out, 32, amount still owed.
- o_done, out, 1, one-cycle pulse at the end of a return.
- o_short, out, 1, valid with o_done; 1 when o_remaining != 0.
- i_refill, in, NUM_COINS, each set bit adds one coin to that denomination's stock.
- o_stock_empty, out, NUM_COINS, bit j is 1 when stock[j] == 0.

Function
REQ-003 The FSM SHALL have four states: IDLE, SELECT, ISSUE and DONE, with an encoding of 2 bits.
REQ-004 In IDLE, o_ready SHALL be 1. On i_start=1, the block SHALL latch i_amount into o_remaining and go to SELECT. In every other state, o_ready SHALL be 0 and i_start SHALL be ignored.
REQ-005 In SELECT, the block SHALL pick the highest j such that COIN_VAL[j] <= o_remaining and stock[j] > 0.
- If such a j exists, the block SHALL register o_coin = one-hot(j), set o_coin_valid=1 and go to ISSUE.
- If none exists, the block SHALL go to DONE.
REQ-006 In ISSUE, o_coin_valid and o_coin SHALL hold stable until the edge on which i_coin_ack=1.
REQ-007 On the edge on which i_coin_ack=1 in ISSUE, the block SHALL:
- reduce o_remaining by COIN_VAL[j];
- reduce stock[j] by 1;
- clear o_coin_valid and o_coin;
- go to SELECT.
REQ-008 When o_coin_valid=0, i_coin_ack SHALL be ignored.
REQ-009 In DONE, o_done SHALL be 1 for exactly one cycle, with o_short = (o_remaining != 0). The next state SHALL be IDLE.
REQ-010 o_remaining SHALL hold its final value in IDLE until the next accepted i_start.
REQ-011 Latency: with i_start accepted at edge T, o_coin_valid SHALL first be 1 in the cycle after edge T+1. With i_coin_ack held at 1, coins SHALL issue every 2 cycles.
REQ-012 A return of i_amount=0 SHALL pass IDLE, SELECT, DONE and issue no coin, with o_short=0.
REQ-013 Refill on bit j SHALL increment stock[j]; when stock[j] is already 2^STOCK_W-1, the refill SHALL be ignored.
REQ-014 If a refill of j and an acknowledged coin of j fall on the same edge, stock[j] SHALL be unchanged.
REQ-015 Refill SHALL be accepted in every state.
REQ-016 o_stock_empty SHALL be combinational from the stock counters.
REQ-017 All arithmetic on o_remaining SHALL be unsigned 32-bit. Subtraction SHALL never underflow, guaranteed by the selection rule in REQ-005.

Reset
REQ-018 When reset_n=0 at a clock edge, the block SHALL set:
- state to IDLE;
- o_coin_valid=0, o_coin=0, o_done=0, o_short=0;
- o_remaining=0;
- every stock[j]=INIT_STOCK.
This applies in any state, including mid-return. A coin offered when reset is applied SHALL be abandoned without a stock decrement.
REQ-019 o_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-020 The bench SHALL cover at least these directed scenarios:
- Default stock; i_amount=1600; ack tied to 1. Required: coins 1000, 500, 100 in order; o_done with o_short=0; o_remaining=0; stocks 9/9/9.
- i_amount=150. Required: one 100 coin; o_done with o_short=1; o_remaining=50.
- i_amount=0. Required: no o_coin_valid; o_done=1 two cycles after the start edge; o_short=0.
- Stock[2] drained to 0; i_amount=2000. Required: four 500 coins; o_stock_empty[2]=1 throughout; o_short=0.
- Ack withheld 3 cycles on the first coin of a 500 return. Required: o_coin_valid and o_coin stable all 3 cycles; single decrement on the ack edge.
- Reset applied while in ISSUE. Required: next cycle o_ready=1, o_coin_valid=0, o_remaining=0, stocks=10.
- i_refill[1] on the same edge as the ack of a 500 coin. Required: stock[1] unchanged.
